// File: rtl/three_phase_step_gen_if.sv
// rtl/three_phase_step_gen_if.sv - tick/control inputs and gate/step outputs of the six-step sequencer
interface three_phase_step_gen_if #(
    parameter int STEP_W = 16
);
    logic              clkTickI;
    logic              enI;
    logic              dirI;
    logic [STEP_W-1:0] stepPeriodI;
    logic [2:0]        hiO;
    logic [2:0]        loO;
    logic [2:0]        stepIdxO;
    logic              stepStrobeO;

    modport master (
        output clkTickI, enI, dirI, stepPeriodI,
        input  hiO, loO, stepIdxO, stepStrobeO
    );

    modport slave (
        input  clkTickI, enI, dirI, stepPeriodI,
        output hiO, loO, stepIdxO, stepStrobeO
    );
endinterface

// File: rtl/three_phase_step_gen.sv
// rtl/three_phase_step_gen.sv - six-step commutation sequencer with dead time, driven by divided-clock ticks
module three_phase_step_gen #(
    parameter int STEP_W     = 16,
    parameter int DEAD_TICKS = 2
) (
    input  logic                     clk50mhzI,
    input  logic                     nRst,
    three_phase_step_gen_if.slave    io
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DEAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    localparam logic [STEP_W:0] DEAD_W  = (STEP_W+1)'(DEAD_TICKS);
    localparam logic [STEP_W:0] DEAD_P1 = (STEP_W+1)'(DEAD_TICKS + 1);
    localparam logic [1:0]      ST_AFTER_ADV = (DEAD_TICKS == 0) ? ST_RUN : ST_DEAD;

    logic [1:0]        state_q, state_d;
    logic [STEP_W-1:0] cnt_q, cnt_d;
    logic [2:0]        step_q, step_d;
    logic              tick_r_q, tick_r_d;
    logic [2:0]        hi_q, hi_d;
    logic [2:0]        lo_q, lo_d;
    logic              strobe_q, strobe_d;

    logic              tick;
    logic [STEP_W:0]   cnt_inc;
    logic [STEP_W:0]   peff;
    logic [2:0]        step_adv;
    logic              legal;
    logic [5:0]        pattern;

    // {hi[2:0], lo[2:0]} per step; bit0 U, bit1 V, bit2 W
    function automatic logic [5:0] gate_pattern(input logic [2:0] s);
        logic [5:0] p;
        case (s)
            3'd0:    p = {3'b001, 3'b010};
            3'd1:    p = {3'b001, 3'b100};
            3'd2:    p = {3'b010, 3'b100};
            3'd3:    p = {3'b010, 3'b001};
            3'd4:    p = {3'b100, 3'b001};
            3'd5:    p = {3'b100, 3'b010};
            default: p = 6'b000000;
        endcase
        return p;
    endfunction

    always_comb begin
        tick     = io.clkTickI & ~tick_r_q;
        tick_r_d = io.clkTickI;
        cnt_inc  = {1'b0, cnt_q} + {{STEP_W{1'b0}}, 1'b1};
        peff     = ({1'b0, io.stepPeriodI} > DEAD_W) ? {1'b0, io.stepPeriodI} : DEAD_P1;

        if (io.dirI) begin
            step_adv = (step_q == 3'd0) ? 3'd5 : step_q - 3'd1;
        end else begin
            step_adv = (step_q == 3'd5) ? 3'd0 : step_q + 3'd1;
        end

        legal = (state_q != 2'd3) && (step_q <= 3'd5);

        state_d  = state_q;
        cnt_d    = cnt_q;
        step_d   = step_q;
        strobe_d = 1'b0;

        if (!legal) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            step_d  = 3'd0;
        end else if (!io.enI) begin
            // disable beats a coincident tick: no advance, no strobe
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d   = '0;
                    state_d = (DEAD_TICKS == 0) ? ST_RUN : ST_DEAD;
                end
                ST_DEAD: begin
                    if (tick) begin
                        cnt_d = cnt_inc[STEP_W-1:0];
                        if (cnt_inc >= DEAD_W) begin
                            state_d = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (tick) begin
                        if (cnt_inc >= peff) begin
                            step_d   = step_adv;
                            cnt_d    = '0;
                            strobe_d = 1'b1;
                            state_d  = ST_AFTER_ADV;
                        end else begin
                            cnt_d = cnt_inc[STEP_W-1:0];
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        // gates are registered from the next state so they track it with one clock of latency
        pattern = gate_pattern(step_d);
        hi_d    = 3'b000;
        lo_d    = 3'b000;
        if (state_d == ST_RUN) begin
            hi_d = pattern[5:3];
            lo_d = pattern[2:0];
        end
    end

    always_ff @(posedge clk50mhzI or negedge nRst) begin
        if (!nRst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            step_q   <= 3'd0;
            tick_r_q <= 1'b1;
            hi_q     <= 3'b000;
            lo_q     <= 3'b000;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            step_q   <= step_d;
            tick_r_q <= tick_r_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            strobe_q <= strobe_d;
        end
    end

    assign io.hiO         = hi_q;
    assign io.loO         = lo_q;
    assign io.stepIdxO    = step_q;
    assign io.stepStrobeO = strobe_q;
endmodule

// File: tb/tb_three_phase_step_gen.sv
// tb/tb_three_phase_step_gen.sv - scoreboard bench for three_phase_step_gen against a tick-count reference model
module tb_three_phase_step_gen;
    localparam int STEP_W = 16;
    localparam int DEAD   = 2;

    logic clk;
    logic nRst;

    three_phase_step_gen_if #(.STEP_W(STEP_W)) bus ();

    three_phase_step_gen #(.STEP_W(STEP_W), .DEAD_TICKS(DEAD)) dut (
        .clk50mhzI (clk),
        .nRst      (nRst),
        .io        (bus.slave)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // expected outputs after each clock: {step[2:0], hi[2:0], lo[2:0], strobe}
    logic [9:0] exp_q[$];

    int hi_tab[6] = '{1, 1, 2, 2, 4, 4};
    int lo_tab[6] = '{2, 4, 4, 1, 1, 2};

    int m_step;
    int m_since;
    bit m_on;
    bit m_prev;

    // Model: a step is a run of ticks counted from its start; gates are on once DEAD ticks have elapsed
    always @(posedge clk) begin
        bit         tk;
        bit         strb;
        int         peff;
        logic [2:0] h;
        logic [2:0] l;
        cyc++;
        if (!nRst) begin
            m_step  = 0;
            m_since = 0;
            m_on    = 0;
            m_prev  = 1;
        end else begin
            tk     = bus.clkTickI && !m_prev;
            m_prev = bus.clkTickI;
            strb   = 0;
            if (!bus.enI) begin
                m_on    = 0;
                m_since = 0;
            end else if (!m_on) begin
                m_on    = 1;
                m_since = 0;
            end else if (tk) begin
                peff = (int'(bus.stepPeriodI) > DEAD) ? int'(bus.stepPeriodI) : DEAD + 1;
                if (m_since + 1 >= peff) begin
                    m_step  = bus.dirI ? (m_step + 5) % 6 : (m_step + 1) % 6;
                    m_since = 0;
                    strb    = 1;
                end else begin
                    m_since = m_since + 1;
                end
            end
            h = 3'b000;
            l = 3'b000;
            if (m_on && m_since >= DEAD) begin
                h = 3'(hi_tab[m_step]);
                l = 3'(lo_tab[m_step]);
            end
            exp_q.push_back({3'(m_step), h, l, strb});
        end
    end

    always @(negedge clk) begin
        logic [9:0] got;
        logic [9:0] want;
        if (nRst && exp_q.size() > 0) begin
            want = exp_q.pop_front();
            got  = {bus.stepIdxO, bus.hiO, bus.loO, bus.stepStrobeO};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL outputs cyc=%0d got step=%0d hi=%b lo=%b strb=%b exp step=%0d hi=%b lo=%b strb=%b",
                         cyc, got[9:7], got[6:4], got[3:1], got[0], want[9:7], want[6:4], want[3:1], want[0]);
            end
            total++;
            if ((bus.hiO & bus.loO) != 3'b000 || !$onehot0(bus.hiO) || !$onehot0(bus.loO)) begin
                bad++;
                $display("FAIL safety cyc=%0d got hi=%b lo=%b exp disjoint one-hot", cyc, bus.hiO, bus.loO);
            end
        end
    end

    task automatic check_zero(input string name);
        logic [9:0] got;
        got = {bus.stepIdxO, bus.hiO, bus.loO, bus.stepStrobeO};
        total++;
        if (got !== 10'd0) begin
            bad++;
            $display("FAIL %s got %h exp 000", name, got);
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            bus.clkTickI = ~bus.clkTickI;
        end
    endtask

    task automatic random_run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if ($urandom_range(0, 2) == 0) bus.clkTickI = ~bus.clkTickI;
            if ($urandom_range(0, 59) == 0) bus.enI = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 39) == 0) bus.dirI = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 29) == 0) bus.stepPeriodI = STEP_W'($urandom_range(0, 12));
        end
    endtask

    initial begin
        clk             = 0;
        nRst            = 0;
        bus.clkTickI    = 0;
        bus.enI         = 0;
        bus.dirI        = 0;
        bus.stepPeriodI = 16'd10;

        cycles(6);
        #2;
        check_zero("reset_hold");
        @(posedge clk);
        #1;
        bus.clkTickI = 1;
        @(negedge clk);
        nRst = 1;

        // forward run
        bus.enI = 1;
        cycles(300);
        // reverse, then a mid-step direction flip
        bus.dirI = 1;
        cycles(160);
        bus.dirI = 0;
        cycles(7);
        bus.dirI = 1;
        cycles(100);
        // period clamp
        bus.stepPeriodI = 16'd0;
        cycles(60);
        bus.stepPeriodI = 16'd1;
        cycles(60);
        // mid-step period drop
        bus.stepPeriodI = 16'd10;
        cycles(40);
        bus.stepPeriodI = 16'd4;
        cycles(40);
        // enable abort and resume
        bus.enI = 0;
        cycles(10);
        bus.enI = 1;
        cycles(60);
        // tick and enable fall in the same cycle
        @(posedge clk);
        #1;
        bus.clkTickI = ~bus.clkTickI;
        bus.enI      = 0;
        cycles(5);
        bus.enI = 1;

        random_run(2500);

        // asynchronous reset mid-run
        bus.enI = 1;
        cycles(25);
        @(posedge clk);
        #3;
        nRst = 0;
        exp_q.delete();
        #1;
        check_zero("async_reset");
        cycles(3);
        @(negedge clk);
        nRst = 1;
        random_run(1500);

        @(negedge clk);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/three_phase_step_gen.md
# three_phase_step_gen

Six-step (trapezoidal) commutation sequencer for the three-phase motor drive. It sits directly downstream of the 50 MHz clock divider and uses the divided clock as its time base. Each rising edge of the divided clock is one tick. The block counts a programmable number of ticks per commutation step, walks the six-step table forward or in reverse, and inserts a programmable dead time at every step change. It drives registered high-side and low-side gate enables for phases U, V and W.

## Interface
- STEP_W, 16: width of the step-period input and the tick counter.
- DEAD_TICKS, 2: dead-time length in ticks, all gates off. 0 disables dead time.
- clk50mhzI  input  1  system clock, 50 MHz; the only clock.
- nRst  input  1  reset, asynchronous, active-low.
- clkTickI  input  1  divided clock from the divider, same domain; each 0→1 edge is one tick.
- enI  input  1  run enable.
- dirI  input  1  direction: 0 forward (step +1), 1 reverse (step −1).
- stepPeriodI  input  STEP_W  ticks per commutation step, measured advance-to-advance.
- hiO  output  3  high-side enables, bit0 U, bit1 V, bit2 W.
- loO  output  3  low-side enables, same bit order.
- stepIdxO  output  3  current step, 0..5.
- stepStrobeO  output  1  one-cycle pulse on each step advance.

## Operation
- Tick detect:
  - tickR <= clkTickI; tick = clkTickI & ~tickR.
  - tickR resets to 1, so a high clkTickI at reset release is not counted as a tick.
- Six-step table (hi phase / lo phase, third phase floats):
  - step 0: U/V
  - step 1: U/W
  - step 2: V/W
  - step 3: V/U
  - step 4: W/U
  - step 5: W/V
- Effective period: Peff = max(stepPeriodI, DEAD_TICKS+1). This covers stepPeriodI = 0.
- States:
  - IDLE: all gates 0; cnt held at 0; stepIdx held. Go to DEAD when enI=1. If DEAD_TICKS=0, go directly to RUN.
  - DEAD: all gates 0; cnt increments on each tick. On a tick with cnt+1 == DEAD_TICKS, go to RUN.
  - RUN: gates follow the table at stepIdx; cnt increments on each tick. On a tick with cnt+1 >= Peff:
    - stepIdx advances; forward wraps 5→0, reverse wraps 0→5.
    - cnt clears to 0.
    - stepStrobeO pulses.
    - Next state is DEAD, or RUN if DEAD_TICKS=0.
- The `>=` compare means a mid-step decrease of stepPeriodI below the current count advances on the very next tick. No step is ever lost.
- dirI is sampled only on the advance cycle. stepPeriodI is sampled on every tick.
- enI=0 in any state: go to IDLE on the next clock; gates 0; stepIdx retained.
  - Re-enable always passes through DEAD before any gate turns on.
  - Re-enable resumes at the retained step.
- Hi and lo of the same phase are never both 1. Any state/step encoding outside the legal set forces all gates 0 and returns the machine to IDLE.

## Timing
- Reset values:
  - state IDLE, cnt 0, stepIdx 0, tickR 1
  - hiO 3'b000, loO 3'b000, stepIdxO 0, stepStrobeO 0
- All outputs are registered and update one clk50mhzI cycle after the tick edge that causes the change.
- Advance cycle: one clock after the qualifying tick, stepIdxO takes the new value, stepStrobeO=1 for exactly one clock, and hiO/loO=0.
- After DEAD_TICKS further ticks, the new pattern appears one clock after the last dead tick.
- Period: consecutive stepStrobeO pulses are exactly Peff ticks apart. Gates are on for Peff−DEAD_TICKS ticks per step.
- Enable latency:
  - enI rise → first gate on one clock after the DEAD_TICKS-th subsequent tick.
  - enI fall → gates 0 on the next clock.
- Tick and enI fall in the same cycle: enI wins, with no advance and no strobe.
- Asynchronous reset mid-step: outputs go to 0 immediately. After release the block waits in IDLE for enI, starting from step 0.

## Test plan
- Reset: hold nRst=0 with clkTickI toggling → hiO=loO=0, stepIdxO=0, stepStrobeO=0. Release with clkTickI=1 → no tick counted.
- Forward run: DEAD_TICKS=2, stepPeriodI=10, enI=1, dirI=0.
  - After 2 ticks: hiO=001, loO=010.
  - Strobe every 10 ticks; stepIdxO steps 0,1,2,3,4,5,0.
  - Gates 0 for exactly 2 ticks after each strobe.
- Reverse wrap: from step 0 with dirI=1 → stepIdxO=5, then hiO=100, loO=010. Flip dirI mid-step → takes effect only at the next advance.
- Period clamp: stepPeriodI=0, then 1 (DEAD_TICKS=2) → strobes 3 ticks apart. Drop stepPeriodI 10→4 when cnt=7 → advance on the next tick.
- Enable abort: drop enI at step 3 mid-RUN → gates 0 the next clock, stepIdxO stays 3, no strobe. Re-raise enI → 2 dead ticks, then hiO=010, loO=001.
- Safety: across a randomized run with enI/dirI/stepPeriodI changing, hiO & loO == 0 every cycle, and at most one hi bit and one lo bit are set.
